// File: rtl/demux_stream_if.sv
// rtl/demux_stream_if.sv - producer/consumer bundle for the registered 1-to-N stream demux.
interface demux_stream_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 8
);
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CNT_W-1:0]          drop_count;

  // master: the environment driving words in and pulling them out
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_count
  );

  // slave: the demux itself
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_count
  );
endinterface

// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - registered 1-to-N stream demux with one-entry channel buffers and a saturating drop counter.
module demux_stream #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  demux_stream_if.slave  bus
);

  logic [CHANNELS-1:0] full;
  logic [WIDTH-1:0]    data [CHANNELS];
  logic [CNT_W-1:0]    drop_q;

  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] drain;
  logic [CHANNELS-1:0] can_take;
  logic                in_range;
  logic                in_ready;
  logic                accept;

  // One-hot decode avoids indexing full[] with a select that may exceed CHANNELS-1.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign drain    = full & bus.out_ready;
  assign can_take = ~full | bus.out_ready;
  assign in_range = |sel_hit;

  // Out-of-range words are always taken so they can be counted and discarded.
  assign in_ready = in_range ? |(sel_hit & can_take) : 1'b1;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      drop_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (accept && sel_hit[k]) begin
          full[k] <= 1'b1;
        end else if (drain[k]) begin
          full[k] <= 1'b0;
        end
      end
      if (accept && !in_range && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Buffer contents need no reset: they are masked whenever full is clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (!rst && accept && sel_hit[k]) begin
        data[k] <= bus.in_data;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_out
      assign bus.out_data[g*WIDTH +: WIDTH] = full[g] ? data[g] : '0;
    end
  endgenerate

  assign bus.out_valid  = full;
  assign bus.in_ready   = in_ready;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - directed self-checking bench for demux_stream.
module tb_demux_stream;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  demux_stream_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) b1 ();
  demux_stream_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) b2 ();

  demux_stream #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  demux_stream #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.in_valid = 1'b0; b1.in_sel = '0; b1.in_data = '0; b1.out_ready = '0;
    b2.in_valid = 1'b0; b2.in_sel = '0; b2.in_data = '0; b2.out_ready = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0000", b1.out_valid);
    end
    vectors++;
    if (b1.out_data !== 16'h0000) begin
      miscompares++; $display("FAIL reset_out_data got %h want 0000", b1.out_data);
    end
    vectors++;
    if (b1.drop_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_drop_count got %0d want 0", b1.drop_count);
    end
    vectors++;
    if (b1.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", b1.in_ready);
    end
    step();
  endtask

  task automatic test_routing();
    logic [3:0] words [4];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    b1.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1'b1; b1.in_sel = 2'(i); b1.in_data = words[i];
      #1;
      vectors++;
      if (b1.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL route_in_ready[%0d] got %b want 1", i, b1.in_ready);
      end
      step();
    end
    b1.in_valid = 1'b0;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b1111) begin
      miscompares++; $display("FAIL route_out_valid got %b want 1111", b1.out_valid);
    end
    vectors++;
    if (b1.out_data !== 16'hDCBA) begin
      miscompares++; $display("FAIL route_out_data got %h want DCBA", b1.out_data);
    end
    b1.in_valid = 1'b1; b1.in_sel = 2'd2; b1.in_data = 4'hE;
    #1;
    vectors++;
    if (b1.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL route_full_in_ready got %b want 0", b1.in_ready);
    end
    step();
    b1.in_valid = 1'b0;
    #1;
    vectors++;
    if (b1.out_data !== 16'hDCBA) begin
      miscompares++; $display("FAIL route_no_overwrite got %h want DCBA", b1.out_data);
    end
    b1.out_ready = 4'b1111;
    step();
    b1.out_ready = 4'b0000;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0000 || b1.out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL route_drain got valid %b data %h want 0000/0000", b1.out_valid, b1.out_data);
    end
  endtask

  task automatic test_replace();
    b1.out_ready = 4'b0000;
    b1.in_valid = 1'b1; b1.in_sel = 2'd1; b1.in_data = 4'h3;
    step();
    b1.in_data = 4'h9;
    #1;
    vectors++;
    if (b1.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL stall_own_in_ready got %b want 0", b1.in_ready);
    end
    b1.in_sel = 2'd0;
    #1;
    vectors++;
    if (b1.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_other_in_ready got %b want 1", b1.in_ready);
    end
    b1.in_valid = 1'b1; b1.in_sel = 2'd1; b1.in_data = 4'h7; b1.out_ready = 4'b0010;
    #1;
    vectors++;
    if (b1.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL replace_in_ready got %b want 1", b1.in_ready);
    end
    vectors++;
    if (b1.out_data[7:4] !== 4'h3) begin
      miscompares++; $display("FAIL replace_old_word got %h want 3", b1.out_data[7:4]);
    end
    step();
    b1.in_valid = 1'b0; b1.out_ready = 4'b0000;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0010) begin
      miscompares++; $display("FAIL replace_out_valid got %b want 0010", b1.out_valid);
    end
    vectors++;
    if (b1.out_data !== 16'h0070) begin
      miscompares++; $display("FAIL replace_out_data got %h want 0070", b1.out_data);
    end
    b1.out_ready = 4'b0010;
    step();
    b1.out_ready = 4'b0000;
  endtask

  task automatic test_streaming();
    b1.out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      b1.in_valid = 1'b1; b1.in_sel = 2'd0; b1.in_data = 4'(i + 1);
      #1;
      vectors++;
      if (b1.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, b1.in_ready);
      end
      if (i > 0) begin
        vectors++;
        if (b1.out_valid !== 4'b0001 || b1.out_data !== 16'(i)) begin
          miscompares++;
          $display("FAIL stream_word[%0d] got valid %b data %h want 0001/%h", i, b1.out_valid, b1.out_data, 16'(i));
        end
      end
      step();
    end
    b1.in_valid = 1'b0;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0001 || b1.out_data !== 16'h0008) begin
      miscompares++; $display("FAIL stream_last got valid %b data %h want 0001/0008", b1.out_valid, b1.out_data);
    end
    step();
    b1.out_ready = 4'b0000;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL stream_empty got %b want 0000", b1.out_valid);
    end
  endtask

  task automatic test_drop();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    b2.out_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      b2.in_valid = 1'b1; b2.in_sel = 2'd3; b2.in_data = 4'(i + 4);
      #1;
      vectors++;
      if (b2.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL drop_in_ready[%0d] got %b want 1", i, b2.in_ready);
      end
      step();
      vectors++;
      if (b2.drop_count !== exp_cnt[i] || b2.out_valid !== 3'b000) begin
        miscompares++;
        $display("FAIL drop_count[%0d] got cnt %0d valid %b want %0d/000", i, b2.drop_count, b2.out_valid, exp_cnt[i]);
      end
    end
    b2.in_valid = 1'b0;
  endtask

  task automatic test_midreset();
    b1.out_ready = 4'b0000;
    b1.in_valid = 1'b1; b1.in_sel = 2'd0; b1.in_data = 4'h5;
    step();
    b1.in_sel = 2'd2; b1.in_data = 4'h9;
    step();
    b1.in_valid = 1'b0;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0101 || b1.out_data !== 16'h0905) begin
      miscompares++; $display("FAIL prereset_state got valid %b data %h want 0101/0905", b1.out_valid, b1.out_data);
    end
    rst = 1'b1;
    b1.in_valid = 1'b1; b1.in_sel = 2'd1; b1.in_data = 4'hE;
    b2.in_valid = 1'b1; b2.in_sel = 2'd3;
    step();
    rst = 1'b0;
    b1.in_valid = 1'b0; b2.in_valid = 1'b0;
    #1;
    vectors++;
    if (b1.out_valid !== 4'b0000 || b1.out_data !== 16'h0000) begin
      miscompares++; $display("FAIL midreset_out got valid %b data %h want 0000/0000", b1.out_valid, b1.out_data);
    end
    vectors++;
    if (b1.drop_count !== 8'd0 || b2.drop_count !== 2'd0) begin
      miscompares++; $display("FAIL midreset_drop got %0d/%0d want 0/0", b1.drop_count, b2.drop_count);
    end
    step();
    vectors++;
    if (b1.out_valid !== 4'b0000 || b2.drop_count !== 2'd0) begin
      miscompares++; $display("FAIL midreset_word_absent got valid %b drop %0d want 0000/0", b1.out_valid, b2.drop_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_routing();
    test_replace();
    test_streaming();
    test_drop();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
